// File: rtl/ram_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ram_rmw_adapter
// Description : Request-side front end for the word-wide data RAM. Turns
//               byte-strobed load/store requests into whole-word RAM
//               accesses. Partial stores use read-modify-write. Each
//               accepted request gets one response through a valid/ready
//               handshake.
// Option      : RAM_RMW_RANGE_CHK_EN - when defined, addresses beyond DEPTH
//               words are rejected with rsp_err_o; when undefined they alias
//               modulo DEPTH and rsp_err_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rmw_adapter #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    // The word index width must cover exactly DEPTH words.
    generate
        if (DEPTH != (1 << AW)) begin : g_depth_check
            $error("ram_rmw_adapter: DEPTH must equal 2**AW");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;   // old word captured in RD for loads
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_data_q, ram_data_d;

    logic [31:0] w_word_addr;
    logic        w_accept;

    // RAM byte address of the requested word; bits above the index are dropped.
    assign w_word_addr = {{(30 - AW){1'b0}}, req_addr_i[AW+1:2], 2'b00};
    assign w_accept    = req_valid_i & req_ready_q;

`ifdef RAM_RMW_RANGE_CHK_EN
    logic w_range_err;
    logic rsp_err_q, rsp_err_d;
    logic w_unused_addr;

    assign w_range_err   = |req_addr_i[31:AW+2];
    assign w_unused_addr = ^req_addr_i[1:0];
`else
    logic w_unused_addr;

    assign w_unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};
`endif

    // Byte-lane merge: strobed lanes come from the store data, the rest
    // from the word read back from the RAM.
    function automatic logic [31:0] merge_lanes(input logic [31:0] new_w,
                                                input logic [31:0] old_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                r[8*n +: 8] = new_w[8*n +: 8];
            end
        end
        return r;
    endfunction

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
`ifdef RAM_RMW_RANGE_CHK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d        = req_we_i;
                    be_d        = req_be_i;
                    wdata_d     = req_wdata_i;
                    req_ready_d = 1'b0;
`ifdef RAM_RMW_RANGE_CHK_EN
                    if (w_range_err) begin
                        // Rejected without touching the RAM.
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                    end else
`endif
                    if (!req_we_i) begin
                        state_d    = S_RD;
                        ram_addr_d = w_word_addr;
                    end else if (req_be_i == 4'hF) begin
                        // Full-word store needs no read of the old word.
                        state_d    = S_WR;
                        ram_addr_d = w_word_addr;
                        ram_data_d = req_wdata_i;
                        ram_we_d   = 1'b1;
                    end else if (req_be_i == 4'h0) begin
                        // Nothing to write: acknowledge immediately.
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
`ifdef RAM_RMW_RANGE_CHK_EN
                        rsp_err_d   = 1'b0;
`endif
                    end else begin
                        state_d    = S_RD;
                        ram_addr_d = w_word_addr;
                    end
                end
            end
            S_RD: begin
                if (we_q) begin
                    // Merge against the word being read this cycle.
                    state_d    = S_WR;
                    ram_we_d   = 1'b1;
                    ram_data_d = merge_lanes(wdata_q, ram_data_i, be_q);
                end else begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ram_data_i;
`ifdef RAM_RMW_RANGE_CHK_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            S_WR: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
`ifdef RAM_RMW_RANGE_CHK_EN
                rsp_err_d   = 1'b0;
`endif
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
`ifdef RAM_RMW_RANGE_CHK_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'h0;
            ram_data_q  <= 32'h0;
`ifdef RAM_RMW_RANGE_CHK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
`ifdef RAM_RMW_RANGE_CHK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    // Gating with rst kills a write whose commit edge is a reset edge.
    assign ram_we_o    = ram_we_q & rst;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
`ifdef RAM_RMW_RANGE_CHK_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rmw_adapter
// Description : Scoreboard bench for ram_rmw_adapter with a behavioural RAM.
//               Expected responses are queued at issue time and popped by an
//               independent response monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rmw_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [3:0]  req_be_i = 4'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          we_count = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] mem [0:4095];

    ram_rmw_adapter #(.DEPTH(4096), .AW(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, returns 0 during reset.
    assign ram_data_i = rst ? mem[ram_addr_o[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we_o) begin
            mem[ram_addr_o[13:2]] <= ram_data_o;
            we_count   <= we_count + 1;
            last_wdata <= ram_data_o;
            last_waddr <= ram_addr_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitor: latency on first valid cycle, stability under
    // backpressure, and data/err at the handshake.
    logic        in_rsp = 1'b0;
    logic        prev_ready = 1'b1;
    logic [31:0] prev_rdata = 32'h0;
    logic        prev_err = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            in_rsp = 1'b0;
        end else if (rsp_valid_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
            end else begin
                if (!in_rsp) begin
                    chk("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
                    in_rsp = 1'b1;
                end else if (!prev_ready) begin
                    chk("hold_rdata", rsp_rdata_o, prev_rdata);
                    chk("hold_err", 32'(rsp_err_o), 32'(prev_err));
                end
                if (rsp_ready_i) begin
                    chk("rsp_rdata", rsp_rdata_o, sb_q[0].rdata);
                    chk("rsp_err", 32'(rsp_err_o), 32'(sb_q[0].err));
                    void'(sb_q.pop_front());
                    in_rsp = 1'b0;
                end
            end
        end
        prev_ready = rsp_ready_i;
        prev_rdata = rsp_rdata_o;
        prev_err   = rsp_err_o;
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit push, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, output int acc);
        int   guard;
        exp_t e;
        @(negedge clk);
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        req_valid_i = 1'b1;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 32'(guard), 32'h0);
        acc = cyc;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            e.acc   = acc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((sb_q.size() != 0 || !req_ready_o) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("done_timeout", 32'(guard), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, wc;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]  = 32'hCAFEF00D;
        mem[8]  = 32'h11223344;
        mem[12] = 32'h55667788;
        mem[16] = 32'h0BADCAFE;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'h0);
        chk("rst_ram_we", 32'(ram_we_o), 32'h0);
        chk("rst_ram_addr", ram_addr_o, 32'h0);
        chk("rst_ram_data", ram_data_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Full store then load.
        wc = we_count;
        issue(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0, 2, a0);
        wait_done();
        chk("full_store_we_pulses", 32'(we_count - wc), 32'h1);
        chk("full_store_waddr", last_waddr, 32'h0000_0010);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, a0);
        wait_done();

        // Partial store merge.
        wc = we_count;
        issue(1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h0, 1'b0, 3, a0);
        wait_done();
        chk("merge_we_pulses", 32'(we_count - wc), 32'h1);
        chk("merge_wdata", last_wdata, 32'h11BB33DD);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0, 2, a0);
        wait_done();

        // Back-to-back loads: one per 3 cycles.
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, a0);
        issue(1'b0, 32'h0000_0023, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0, 2, a1);
        wait_done();
        chk("load_throughput", 32'(a1 - a0), 32'd3);

        // Response backpressure.
        rsp_ready_i = 1'b0;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0, 2, a0);
        for (int g = 0; g < 20 && !rsp_valid_o; g++) @(negedge clk);
        chk("bp_valid_seen", 32'(rsp_valid_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready_low", 32'(req_ready_o), 32'h0);
            chk("bp_valid_held", 32'(rsp_valid_o), 32'h1);
        end
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_at_ack", 32'(req_ready_o), 32'h0);
        @(negedge clk);
        chk("bp_req_ready_after", 32'(req_ready_o), 32'h1);
        wait_done();

        // Zero-strobe store: latency 1, no write.
        wc = we_count;
        issue(1'b1, 32'h0000_0030, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0, 1'b0, 1, a0);
        wait_done();
        chk("zero_be_no_write", 32'(we_count - wc), 32'h0);
        issue(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1'b1, 32'h55667788, 1'b0, 2, a0);
        wait_done();

        // Address beyond DEPTH words.
        wc = we_count;
`ifdef RAM_RMW_RANGE_CHK_EN
        issue(1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1, a0);
        wait_done();
        issue(1'b1, 32'h0000_4000, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b1, 1, a0);
        wait_done();
        chk("range_no_write", 32'(we_count - wc), 32'h0);
        chk("range_word0_intact", mem[0], 32'hCAFEF00D);
`else
        issue(1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0, 2, a0);
        wait_done();
        chk("alias_no_write", 32'(we_count - wc), 32'h0);
`endif

        // Reset during the RD cycle of a partial store.
        wc = we_count;
        issue(1'b1, 32'h0000_0040, 32'h99999999, 4'b0011, 1'b0, 32'h0, 1'b0, 0, a0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(req_ready_o), 32'h1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_mid_ram_we", 32'(ram_we_o), 32'h0);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_rsp_later", 32'(rsp_valid_o), 32'h0);
        chk("rst_mid_no_write", 32'(we_count - wc), 32'h0);
        chk("rst_mid_word_intact", mem[16], 32'h0BADCAFE);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h0BADCAFE, 1'b0, 2, a0);
        wait_done();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
